// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
// UART_TX_PARITY_EN selects 8E1 framing (11 bits) instead of 8N1 (10 bits).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    function automatic int unsigned calc_divisor(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// First-word fall-through synchronous FIFO; pop_data is valid whenever empty is low.
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are exactly AW bits wide, so increments wrap modulo DEPTH.
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter, LSB first, no idle gap between queued bytes.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1); default is 8N1.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic [7:0]                        in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              txd,
    output logic                              tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
    localparam int unsigned DIVISOR = calc_divisor(CLK_HZ, BAUD);
    localparam int unsigned BW      = $clog2(DIVISOR);

    if (DIVISOR < 2) begin : g_divisor_check
        $error("uart_tx_buffered: CLK_HZ/BAUD must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("uart_tx_buffered: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    tx_state_t       state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      data_q, data_d;
    logic            txd_q, txd_d;
    logic            live_q;
    logic            baud_last;
    logic            push, pop;
    logic            fifo_full, fifo_empty;
    logic [7:0]      fifo_data;

    // live_q holds in_ready low until the first edge after reset release.
    assign in_ready = live_q && !fifo_full;
    assign push     = in_valid && in_ready;
    assign tx_busy  = (state_q != IDLE);
    assign txd      = txd_q;

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        data_d    = data_q;
        txd_d     = 1'b1;
        pop       = 1'b0;
        baud_last = (baud_q == BW'(DIVISOR - 1));

        if (state_q != IDLE) baud_d = baud_last ? '0 : baud_q + BW'(1);

        // txd_d reflects the current state, so the line lags the FSM by one cycle.
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    data_d  = fifo_data;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                txd_d = 1'b0;
                if (baud_last) state_d = DATA;
            end
            DATA: begin
                txd_d = data_q[bit_q];
                if (baud_last) begin
                    bit_d = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                    if (bit_q == 3'd7) state_d = PARITY;
`else
                    if (bit_q == 3'd7) state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                txd_d = ^data_q;
                if (baud_last) state_d = STOP;
            end
`endif
            STOP: begin
                if (baud_last) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        data_d  = fifo_data;
                        bit_d   = '0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            txd_q   <= 1'b1;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            txd_q   <= txd_d;
            live_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: accepted bytes are queued, a serial receiver model checks frames.
module tb_uart_tx_buffered;
    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int unsigned DEPTH  = 16;
    localparam int DIV = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, txd, tx_busy;
    logic [4:0] fifo_count;

    int tests = 0;
    int fails = 0;
    int rx_count = 0;
    int busy_run = 0;
    int last_run = 0;
    logic [7:0] exp_q[$];

    uart_tx_buffered #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Length of the most recent contiguous tx_busy window, in cycles.
    always @(negedge clk) begin
        if (tx_busy) busy_run = busy_run + 1;
        else begin
            if (busy_run != 0) last_run = busy_run;
            busy_run = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests = tests + 1;
        if (got !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check("push_accept_timeout", 0, 1);
        else exp_q.push_back(b);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output int peak);
        logic ok;
        ok   = 1'b0;
        peak = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (!tx_busy && fifo_count == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_reached", {31'd0, ok}, 1);
        @(negedge clk);
        #1;
    endtask

    // Receiver model: samples each bit at its midpoint, aborts on reset.
    initial begin
        logic [10:0] bits;
        logic [7:0]  got, expv;
        logic        ab;
        forever begin
            @(negedge clk);
            if (nrst && !txd) begin
                ab   = 1'b0;
                bits = '0;
                for (int b = 0; b < FRAME && !ab; b++) begin
                    for (int c = 0; c < ((b == 0) ? DIV / 2 : DIV) && !ab; c++) begin
                        @(negedge clk);
                        if (!nrst) ab = 1'b1;
                    end
                    bits[b] = txd;
                end
                if (!ab) begin
                    got = bits[8:1];
                    rx_count++;
                    check("rx_start_bit", {31'd0, bits[0]}, 0);
                    check("rx_stop_bit", {31'd0, bits[FRAME-1]}, 1);
                    if (exp_q.size() == 0) begin
                        check("rx_unexpected_frame", {24'd0, got}, 32'hFFFF_FFFF);
                    end else begin
                        expv = exp_q.pop_front();
                        check("rx_data", {24'd0, got}, {24'd0, expv});
`ifdef UART_TX_PARITY_EN
                        check("rx_parity", {31'd0, bits[9]}, {31'd0, ^expv});
`endif
                    end
                end
            end
        end
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: got timeout expected completion");
        fails = fails + 1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int peak, acc, rx0, n;
        logic [7:0] d;

        repeat (3) @(negedge clk);
        check("reset_txd", {31'd0, txd}, 1);
        check("reset_busy", {31'd0, tx_busy}, 0);
        check("reset_ready", {31'd0, in_ready}, 0);
        check("reset_count", {27'd0, fifo_count}, 0);
        nrst = 1'b1;
        #1;
        check("ready_before_edge", {31'd0, in_ready}, 0);
        @(negedge clk);
        check("ready_after_edge", {31'd0, in_ready}, 1);

        // Single byte: pop on N+1, start bit on N+2.
        push_byte(8'h55);
        check("count_after_accept", {27'd0, fifo_count}, 1);
        @(negedge clk);
        check("txd_high_n1", {31'd0, txd}, 1);
        check("busy_n1", {31'd0, tx_busy}, 1);
        check("count_after_pop", {27'd0, fifo_count}, 0);
        @(negedge clk);
        check("start_n2", {31'd0, txd}, 0);
        wait_idle(3000, peak);
        check("busy_len_single", last_run, FRAME * DIV);

        // Back-to-back bytes form one busy window.
        push_byte(8'h41);
        push_byte(8'h42);
        push_byte(8'h43);
        wait_idle(5000, peak);
        check("b2b_peak_count", peak, 2);
        check("busy_len_b2b", last_run, 3 * FRAME * DIV);

        // Fill the FIFO with in_valid held high for 20 cycles.
        acc = 0;
        d   = 8'h00;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = d;
            if (in_ready) begin
                exp_q.push_back(d);
                d = d + 8'd1;
                acc++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("full_accepts", acc, 17);
        check("full_count", {27'd0, fifo_count}, DEPTH);
        check("full_ready", {31'd0, in_ready}, 0);
        wait_idle(20 * FRAME * DIV, peak);

        // Random bytes with random gaps.
        rx0 = rx_count;
        for (int i = 0; i < 25; i++) begin
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 250)) : 0;
            repeat (n) @(negedge clk);
            push_byte(8'($urandom));
        end
        wait_idle(40 * FRAME * DIV, peak);
        check("rx_count_random", rx_count - rx0, 25);

        // Reset mid-frame drops the frame and the queue.
        push_byte(8'hA5);
        push_byte(8'h11);
        push_byte(8'h22);
        n = 0;
        while (txd && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_start_seen", {31'd0, txd}, 0);
        repeat (35) @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        check("mid_reset_txd", {31'd0, txd}, 1);
        check("mid_reset_count", {27'd0, fifo_count}, 0);
        check("mid_reset_busy", {31'd0, tx_busy}, 0);
        check("mid_reset_ready", {31'd0, in_ready}, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        rx0 = rx_count;
        push_byte(8'h3C);
        wait_idle(3000, peak);
        check("rx_after_reset", rx_count - rx0, 1);

        // "Hi\n" through the receiver model.
        rx0 = rx_count;
        push_byte(8'h48);
        push_byte(8'h69);
        push_byte(8'h0A);
        wait_idle(5000, peak);
        check("rx_count_hi", rx_count - rx0, 3);

`ifdef UART_TX_PARITY_EN
        push_byte(8'h07);
        wait_idle(3000, peak);
        check("busy_len_parity", last_run, 110);
        push_byte(8'h03);
        wait_idle(3000, peak);
`endif

        repeat (20) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
